// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-state encoding, datapath widths and the default bubble word.
package cpu_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [INST_W-1:0] NOP_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        REQ,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: PC+4, instruction and valid flag with load, hold and bubble controls.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [INST_W-1:0] NOP_INST = NOP_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              bubble_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [INST_W-1:0] inst_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic              valid_o
);

    logic [ADDR_W-1:0] pc_p1;
    logic [INST_W-1:0] inst_p1;
    logic              vld_p1;

    // IF -> ID boundary; a bubble keeps the PC field so decode still sees the last address
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_p1   <= '0;
            inst_p1 <= NOP_INST;
            vld_p1  <= 1'b0;
        end else if (bubble_i) begin
            inst_p1 <= NOP_INST;
            vld_p1  <= 1'b0;
        end else if (load_i) begin
            pc_p1   <= pc_i;
            inst_p1 <= inst_i;
            vld_p1  <= 1'b1;
        end
    end

    assign pc_o    = pc_p1;
    assign inst_o  = inst_p1;
    assign valid_o = vld_p1;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem req/ack FSM, branch redirect and hazard hold buffer.
// Optional STALL_CNT_EN adds a saturating stall-cycle counter on stall_cnt_o.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [INST_W-1:0] NOP_INST = NOP_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hazard_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [INST_W-1:0] imem_data_i,
    output logic [ADDR_W-1:0] ifid_pc_o,
    output logic [INST_W-1:0] ifid_inst_o,
    output logic              ifid_valid_o
`ifdef STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt_o
`endif
);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt, pc_inc;
    logic              pend, pend_nxt;
    logic [ADDR_W-1:0] target, target_nxt;
    logic [INST_W-1:0] hold_buf;
    logic              buf_ld;
    logic              ifid_load, ifid_bubble;
    logic [INST_W-1:0] ifid_inst_d;

    assign pc_inc = pc + 32'd4;

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        pend_nxt    = pend;
        target_nxt  = target;
        buf_ld      = 1'b0;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_inst_d = imem_data_i;
        case (state)
            REQ: begin
                if (imem_ack_i) begin
                    if (flush_i) begin
                        pc_nxt      = branch_target_i;
                        pend_nxt    = 1'b0;
                        ifid_bubble = 1'b1;
                    end else if (pend) begin
                        // the returning word belongs to the abandoned path
                        pc_nxt      = target;
                        pend_nxt    = 1'b0;
                        ifid_bubble = !hazard_i;
                    end else if (hazard_i) begin
                        buf_ld    = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        pc_nxt    = pc_inc;
                        ifid_load = 1'b1;
                    end
                end else if (flush_i) begin
                    // address must stay stable until ack, so defer the redirect
                    target_nxt  = branch_target_i;
                    pend_nxt    = 1'b1;
                    ifid_bubble = 1'b1;
                end else begin
                    ifid_bubble = !hazard_i;
                end
            end
            HOLD: begin
                if (flush_i) begin
                    pc_nxt      = branch_target_i;
                    ifid_bubble = 1'b1;
                    state_nxt   = REQ;
                end else if (!hazard_i) begin
                    pc_nxt      = pc_inc;
                    ifid_load   = 1'b1;
                    ifid_inst_d = hold_buf;
                    state_nxt   = REQ;
                end
            end
            default: state_nxt = REQ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= REQ;
            pc    <= RESET_PC;
            pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            pend  <= pend_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        target <= target_nxt;
        if (buf_ld) begin
            hold_buf <= imem_data_i;
        end
    end

    assign imem_req_o  = (state == REQ) && !rst_i;
    assign imem_addr_o = pc;

    if_id_reg #(
        .NOP_INST(NOP_INST)
    ) u_if_id_reg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (ifid_load),
        .bubble_i(ifid_bubble),
        .pc_i    (pc_inc),
        .inst_i  (ifid_inst_d),
        .pc_o    (ifid_pc_o),
        .inst_o  (ifid_inst_o),
        .valid_o (ifid_valid_o)
    );

`ifdef STALL_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (hazard_i || ((state == REQ) && !imem_ack_i)) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: per-cycle expected IF/ID and fetch outputs go through a scoreboard queue.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        hazard;
    logic        flush;
    logic [31:0] target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_inst;
    logic        ifid_valid;
`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    logic [7:0]  lat;
    logic [7:0]  wait_cnt;
    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_mis = 0;

    always #5 clk = ~clk;

    if_stage #(
        .RESET_PC(32'h0000_0000),
        .NOP_INST(NOP)
    ) dut (
`ifdef STALL_CNT_EN
        .stall_cnt_o    (stall_cnt),
`endif
        .clk_i          (clk),
        .rst_i          (rst),
        .hazard_i       (hazard),
        .flush_i        (flush),
        .branch_target_i(target),
        .imem_req_o     (imem_req),
        .imem_addr_o    (imem_addr),
        .imem_ack_i     (imem_ack),
        .imem_data_i    (imem_data),
        .ifid_pc_o      (ifid_pc),
        .ifid_inst_o    (ifid_inst),
        .ifid_valid_o   (ifid_valid)
    );

    // memory model: ack after `lat` wait cycles, data = 0x1111_0000 + addr, drops requests on reset
    assign imem_ack  = imem_req && (wait_cnt >= lat);
    assign imem_data = 32'h1111_0000 + imem_addr;

    always @(posedge clk or posedge rst) begin
        if (rst) wait_cnt <= 8'd0;
        else if (!imem_req || imem_ack) wait_cnt <= 8'd0;
        else wait_cnt <= wait_cnt + 8'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, ".req"},  32'(imem_req), 32'd0);
        check_eq({tag, ".addr"}, imem_addr, 32'h0);
        check_eq({tag, ".pc"},   ifid_pc, 32'h0);
        check_eq({tag, ".inst"}, ifid_inst, NOP);
        check_eq({tag, ".vld"},  32'(ifid_valid), 32'd0);
`ifdef STALL_CNT_EN
        check_eq({tag, ".cnt"},  stall_cnt, 32'd0);
`endif
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check_reset(tag);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drive(input logic hz, input logic fl, input logic [31:0] tgt,
                         input logic e_req, input logic [31:0] e_addr,
                         input logic e_vld, input logic [31:0] e_pc, input logic [31:0] e_inst,
                         input string tag);
        exp_t e;
        hazard = hz;
        flush  = fl;
        target = tgt;
        e.req  = e_req;
        e.addr = e_addr;
        e.vld  = e_vld;
        e.pc   = e_pc;
        e.inst = e_inst;
        sb.push_back(e);
        @(posedge clk); #1;
        hazard = 1'b0;
        flush  = 1'b0;
        e = sb.pop_front();
        check_eq({tag, ".req"},  32'(imem_req), 32'(e.req));
        check_eq({tag, ".addr"}, imem_addr, e.addr);
        check_eq({tag, ".vld"},  32'(ifid_valid), 32'(e.vld));
        check_eq({tag, ".pc"},   ifid_pc, e.pc);
        check_eq({tag, ".inst"}, ifid_inst, e.inst);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        rst = 1'b0; hazard = 1'b0; flush = 1'b0; target = '0; lat = 8'd0;
        #2;
        do_reset("rst0");

        // zero-wait sequential fetch, then a two-cycle hazard
        drive(0, 0, 0, 1, 32'd4,  1, 32'd4,  32'h1111_0000, "seq0");
        drive(0, 0, 0, 1, 32'd8,  1, 32'd8,  32'h1111_0004, "seq1");
        drive(0, 0, 0, 1, 32'd12, 1, 32'd12, 32'h1111_0008, "seq2");
        drive(1, 0, 0, 0, 32'd12, 1, 32'd12, 32'h1111_0008, "stall0");
        drive(1, 0, 0, 0, 32'd12, 1, 32'd12, 32'h1111_0008, "stall1");
        drive(0, 0, 0, 1, 32'd16, 1, 32'd16, 32'h1111_000C, "unstall");
        drive(0, 0, 0, 1, 32'd20, 1, 32'd20, 32'h1111_0010, "seq3");

        // flush together with hazard while in HOLD
        drive(1, 0, 0,        0, 32'd20,   1, 32'd20,   32'h1111_0010, "hold");
        drive(1, 1, 32'h100,  1, 32'h100,  0, 32'd20,   NOP,           "hold_flush");
        drive(0, 0, 0,        1, 32'h104,  1, 32'h104,  32'h1111_0100, "tgt0");

        // slow memory, flush in first wait cycle
        lat = 8'd3;
        do_reset("rst1");
        drive(0, 1, 32'h40, 1, 32'h0,  0, 32'h0,  NOP,           "pend0");
        drive(0, 0, 0,      1, 32'h0,  0, 32'h0,  NOP,           "wait1");
        drive(0, 0, 0,      1, 32'h0,  0, 32'h0,  NOP,           "wait2");
        drive(0, 0, 0,      1, 32'h40, 0, 32'h0,  NOP,           "discard");
        drive(0, 0, 0,      1, 32'h40, 0, 32'h0,  NOP,           "w40a");
        drive(0, 0, 0,      1, 32'h40, 0, 32'h0,  NOP,           "w40b");
        drive(0, 0, 0,      1, 32'h40, 0, 32'h0,  NOP,           "w40c");
        drive(0, 0, 0,      1, 32'h44, 1, 32'h44, 32'h1111_0040, "redir");
        drive(0, 0, 0,      1, 32'h44, 0, 32'h44, NOP,           "w44");

        // asynchronous reset with a request outstanding
        do_reset("rst_mid");
        lat = 8'd0;
        drive(0, 0, 0,            1, 32'd4,         1, 32'd4,     32'h1111_0000, "restart");
        drive(0, 1, 32'h200,      1, 32'h200,       0, 32'd4,     NOP,           "flush_ack");
        drive(0, 0, 0,            1, 32'h204,       1, 32'h204,   32'h1111_0200, "tgt1");
        drive(0, 1, 32'hFFFF_FFFC,1, 32'hFFFF_FFFC, 0, 32'h204,   NOP,           "flush_top");
        drive(0, 0, 0,            1, 32'h0,         1, 32'h0,     32'h1110_FFFC, "wrap");
        drive(0, 0, 0,            1, 32'd4,         1, 32'd4,     32'h1111_0000, "post_wrap");

        // second flush while a redirect is pending replaces the target
        lat = 8'd2;
        drive(0, 1, 32'h300, 1, 32'd4,   0, 32'd4,   NOP,           "pendA");
        drive(0, 1, 32'h400, 1, 32'd4,   0, 32'd4,   NOP,           "pendB");
        drive(0, 0, 0,       1, 32'h400, 0, 32'd4,   NOP,           "overwrite");
        drive(0, 0, 0,       1, 32'h400, 0, 32'd4,   NOP,           "w400a");
        drive(0, 0, 0,       1, 32'h400, 0, 32'd4,   NOP,           "w400b");
        drive(0, 0, 0,       1, 32'h404, 1, 32'h404, 32'h1111_0400, "tgt2");

`ifdef STALL_CNT_EN
        // 4 memory-wait cycles then 5 hazard cycles
        lat = 8'd4;
        do_reset("rst_cnt");
        repeat (5) begin
            @(posedge clk); #1;
        end
        lat = 8'd0;
        hazard = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        hazard = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("stall_cnt", stall_cnt, 32'd9);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage pipeline: owns the PC, issues fetch requests to instruction memory over a req/ack handshake, and drives the IF/ID pipeline register consumed by the decode stage and the hazard-detection unit. It is directly upstream of hazard detection and obeys that unit's stall output, holding the PC and IF/ID contents on a load-use hazard. It also accepts a branch redirect from ID, which flushes IF/ID and discards any in-flight fetch.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word inserted into IF/ID as a bubble.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- hazard_i  in  1  stall from hazard detection; hold PC and IF/ID.
- flush_i  in  1  branch taken in ID; redirect fetch to branch_target_i.
- branch_target_i  in  32  redirect address, valid when flush_i=1.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address (word-aligned).
- imem_ack_i  in  1  memory returns imem_data_i this cycle.
- imem_data_i  in  32  fetched instruction.
- ifid_pc_o  out  32  PC+4 of the instruction held in IF/ID.
- ifid_inst_o  out  32  instruction held in IF/ID.
- ifid_valid_o  out  1  IF/ID holds a real instruction (0 = bubble).
- stall_cnt_o  out  32  stall-cycle counter (only with STALL_CNT_EN).

## Operation
- Reset values: pc=RESET_PC, state=REQ, imem_req_o=0 while rst_i=1, imem_addr_o=RESET_PC, ifid_pc_o=0, ifid_inst_o=NOP_INST, ifid_valid_o=0, redirect-pending=0, stall_cnt_o=0.
- States: REQ (request outstanding), HOLD (instruction fetched, held in a one-entry buffer while hazard_i=1).
- REQ: imem_req_o=1, imem_addr_o=pc; address held stable until ack.
  - ack, redirect-pending=0, flush_i=0, hazard_i=0: IF/ID <= {pc+4, imem_data_i, valid=1}; pc <= pc+4; stay REQ.
  - ack, hazard_i=1, flush_i=0: data into buffer; IF/ID held; pc unchanged; go HOLD.
  - ack, redirect-pending=1: data discarded; pc <= saved target; pending cleared; IF/ID bubble unless hazard_i=1 (hold).
  - ack with flush_i=1: data discarded; pc <= branch_target_i; IF/ID bubble.
  - no ack, flush_i=1: save branch_target_i, set redirect-pending; imem_addr_o unchanged; IF/ID bubble.
  - no ack, otherwise: IF/ID bubble if hazard_i=0, held if hazard_i=1.
- HOLD: imem_req_o=0. hazard_i=0: IF/ID <= buffer (valid=1), pc <= pc+4, go REQ. flush_i=1: buffer dropped, pc <= branch_target_i, IF/ID bubble, go REQ.
- Priority: rst_i > flush_i > hazard_i. flush_i and hazard_i together are treated as flush.
- A second flush_i while redirect-pending=1 overwrites the saved target.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- Bubble means ifid_inst_o=NOP_INST, ifid_valid_o=0, ifid_pc_o unchanged.

## Timing
- Fetch-to-IF/ID latency: ack in cycle N, IF/ID updates at the edge ending cycle N, visible in N+1.
- With a zero-wait memory (ack in the cycle of the request), throughput is one instruction per cycle and imem_req_o stays high continuously.
- Flush in cycle N: new address on imem_addr_o in N+1 (no request outstanding) or one cycle after the pending ack.
- hazard_i is sampled every cycle. Hold lasts exactly as many cycles as hazard_i is high.
- Asynchronous reset mid-fetch abandons the request immediately. No ack is expected afterward, and the memory must drop it.

## Configuration
- STALL_CNT_EN defined: stall_cnt_o is present. It increments by 1 each cycle with hazard_i=1, or state=REQ and imem_ack_i=0, and saturates at 32'hFFFF_FFFF. Reset sets it to 0.
- Not defined: port and counter are absent. All other behaviour is identical.

## Structure
- Shared package cpu_pkg:
  - fetch-state enum (REQ, HOLD)
  - INST_W=32, ADDR_W=32
  - default NOP constant
- Sub-module if_id_reg: holds the pc/inst/valid registers with load, hold, and bubble controls. if_stage contains the FSM, PC, redirect logic, buffer and counter.

## Test plan
- Reset, zero-wait memory returning 32'h1111_0000+addr: IF/ID shows pc 4,8,12 with matching instructions on consecutive cycles; valid=1 from the second cycle after reset release.
- hazard_i high for 2 cycles after inst at addr 8 is fetched: IF/ID holds {12, inst@8} during the stall, then shows addr 12 next; no instruction is lost or duplicated.
- 3-cycle-latency memory, flush_i with target 32'h40 in the first wait cycle: imem_addr_o stays at the old address until ack, that data is discarded, and the next request is to 32'h40; IF/ID shows bubbles in between.
- flush_i and hazard_i asserted together in HOLD: buffer dropped, next request to the target, ifid_valid_o=0.
- rst_i asserted mid-request: all outputs return to reset values immediately, and fetch restarts at RESET_PC.
- STALL_CNT_EN defined, 5 hazard cycles plus 4 memory-wait cycles: stall_cnt_o=9. Preloaded near max, the counter saturates at 32'hFFFF_FFFF.
